online_div_scheduler: RTL and testbench
=======================================

# online_div_scheduler

Round-robin scheduler that shares one digit-serial online division unit between `NUM_REQ` requesters. It grants one requester at a time and pulses a clear into the divider. It then streams the granted requester's redundant-digit operands into the divider, followed by `ONLINE_DELAY` zero digits to flush it. It collects the `UNROLLING` result digits, tagged with the requester index. It sits between the operand producers and the `computation_control_v2`-based divider core.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `ID_W`, 2, width of requester index; must satisfy 2^ID_W >= NUM_REQ.
- `UNROLLING`, 64, digits per operand and per result.
- `ONLINE_DELAY`, 2, divider online delay in digits.
- `CNT_WIDTH`, 11, digit counter width; must satisfy UNROLLING+ONLINE_DELAY < 2^CNT_WIDTH.

Ports:
- `clk` input 1: single clock, rising edge.
- `asyn_reset` input 1: synchronous, active-high reset.
- `req` input NUM_REQ: per-requester job request, level.
- `x_digit_in` input 2*NUM_REQ: packed dividend digits; requester i uses bits [2i+1:2i].
- `y_digit_in` input 2*NUM_REQ: packed divisor digits, same packing.
- `grant` output NUM_REQ: one-hot grant, or 0.
- `dig_rd` output 1: granted requester's current digit is consumed at this edge.
- `div_x`, `div_y` output 2 each: digits to divider.
- `div_enable` output 1: divider compute enable.
- `div_clear` output 1: one-cycle divider clear pulse.
- `div_z` input 2: divider result digit for the current enabled cycle.
- `z_out` output 2: registered result digit.
- `z_valid` output 1: `z_out` is valid.
- `z_last` output 1: final result digit of a job.
- `z_id` output ID_W: index of the requester owning `z_out`.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - If any `req` bit is high, select the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Register the winner in `gnt_idx` and go to CLEAR.
- **CLEAR**
  - `grant`=onehot(gnt_idx), `div_clear`=1, counter←0. Next state is FEED.
- **FEED**
  - `grant` held, `dig_rd`=1, `div_enable`=1.
  - `div_x`/`div_y` are combinationally muxed from the granted slice of `x_digit_in`/`y_digit_in`.
  - Counter increments each cycle. After UNROLLING cycles (counter=UNROLLING-1), go to DRAIN.
- **DRAIN**
  - `grant` held, `dig_rd`=0, `div_enable`=1, `div_x`=`div_y`=2'b00.
  - Lasts ONLINE_DELAY cycles, then go to DONE.
- **DONE**
  - `grant`=0, `rr_ptr`←(gnt_idx+1) mod NUM_REQ.
  - If any `req` is high, arbitrate with the new pointer and go straight to CLEAR; otherwise go to IDLE.
- **Result capture**
  - Enabled cycles are indexed c=0..UNROLLING+ONLINE_DELAY-1; FEED is c=0..UNROLLING-1.
  - On each edge ending an enabled cycle with c>=ONLINE_DELAY: `z_out`←`div_z`, `z_valid`←1, `z_id`←gnt_idx.
  - `z_last`←1 when c=UNROLLING+ONLINE_DELAY-1.
  - Otherwise `z_valid`, `z_last`←0; `z_out` and `z_id` hold.
- Digits pass through unchanged; the scheduler does not interpret the encoding.
- `req` is sampled only when arbitrating. Dropping `req` mid-job does not abort the job; all UNROLLING result digits are still delivered.
- Requesters keep `req` high until `grant` and deassert it no later than the `z_last` cycle to avoid re-service. A `req` still high in DONE is re-arbitrated at lowest round-robin priority.
- When `grant` is 0, `div_x` and `div_y` are 0.

## Timing
- Reset, sampled at a rising edge, puts the block in this state on the next cycle:
  - state IDLE;
  - `grant`, `dig_rd`, `div_enable`, `div_clear`, `busy`, `z_valid`, `z_last` = 0;
  - `z_out`=0, `z_id`=0, `rr_ptr`=0, counter=0.
- Reset has priority over all events, including mid-job. A job interrupted by reset produces no further `z_valid` and no `z_last`.
- `req` high at edge t → CLEAR (grant visible) in cycle t+1 → FEED cycles t+2..t+UNROLLING+1.
- Job length: CLEAR through DONE is UNROLLING+ONLINE_DELAY+2 cycles, i.e. 68 at defaults. `grant` is high for UNROLLING+ONLINE_DELAY+1 cycles (67).
- First `z_valid` falls in FEED cycle index ONLINE_DELAY+1. `z_last` coincides with DONE.
- `z_valid` is high for exactly UNROLLING consecutive cycles per job.
- Back-to-back jobs: the next CLEAR follows DONE directly, giving a period of UNROLLING+ONLINE_DELAY+2 cycles.
- `grant`, `dig_rd`, `div_enable`, `div_clear` and `busy` are decoded only from registered state.

## Test plan
- **Reset:** assert `asyn_reset` 1 cycle → all outputs 0. Assert reset at FEED counter=10 → next cycle `busy`=0, `grant`=0, `div_enable`=0, and no `z_valid` ever.
- **Single job:** `req`=4'b0100 at edge t → `grant`=4'b0100 at t+1; `div_clear` 1 cycle; `dig_rd` 64 cycles; `div_enable` 66 cycles; `z_valid` 64 cycles with `z_id`=2; `z_last` at t+68; `busy` 68 cycles.
- **Echo model:** `div_z` = `div_x` delayed 2 enabled cycles, x digits cycling 01,11,00 → `z_out` reproduces that sequence exactly, 64 digits, `z_last` on the 64th.
- **Fairness:** `req`=4'b1111 held → grant order 0,1,2,3,0; DONE→CLEAR with no IDLE; period 68 cycles.
- **Wrap-around:** after serving requester 1, `req`=4'b1001 → requester 3 is granted before requester 0.
- **Mid-job drop:** deassert `req` at FEED counter=20 → the job still completes 64 `z_valid` digits; the block then returns to IDLE.

Source files
------------

// File: rtl/online_div_scheduler.sv
// Round-robin arbiter that time-shares one digit-serial online divider between requesters:
// clear the divider, stream operand digits, flush with zero digits, and tag the result digits.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no job; arbitrate over req from rr_ptr
// S_CLEAR | grant visible, one-cycle divider clear, digit counter zeroed
// S_FEED  | stream UNROLLING operand digits from the granted requester
// S_DRAIN | ONLINE_DELAY zero digits to flush the divider pipeline
// S_DONE  | release grant, advance rr_ptr, re-arbitrate or go idle
module online_div_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 2,
    parameter int CNT_WIDTH    = 11
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] x_digit_in,
    input  logic [2*NUM_REQ-1:0] y_digit_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 dig_rd,
    output logic [1:0]           div_x,
    output logic [1:0]           div_y,
    output logic                 div_enable,
    output logic                 div_clear,
    input  logic [1:0]           div_z,
    output logic [1:0]           z_out,
    output logic                 z_valid,
    output logic                 z_last,
    output logic [ID_W-1:0]      z_id,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FEED_LAST = CNT_WIDTH'(UNROLLING - 1);
    localparam logic [CNT_WIDTH-1:0] JOB_LAST  = CNT_WIDTH'(UNROLLING + ONLINE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] Z_FIRST   = CNT_WIDTH'(ONLINE_DELAY);

    state_t               state;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      rr_ptr_nxt;
    logic [CNT_WIDTH-1:0] dig_cnt;
    logic [NUM_REQ-1:0]   gnt_onehot;
    logic [1:0]           sel_x;
    logic [1:0]           sel_y;
    logic                 granted;

    // First set request at or above the pointer, otherwise the lowest set request (wrap).
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] w;
        logic            found;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[i] && (ID_W'(i) >= p)) begin
                w     = ID_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[i]) begin
                w     = ID_W'(i);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign rr_ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        gnt_onehot = '0;
        sel_x      = 2'b00;
        sel_y      = 2'b00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                gnt_onehot[i] = 1'b1;
                sel_x         = x_digit_in[2*i +: 2];
                sel_y         = y_digit_in[2*i +: 2];
            end
        end
    end

    assign granted    = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    assign grant      = granted ? gnt_onehot : '0;
    assign dig_rd     = (state == S_FEED);
    assign div_enable = (state == S_FEED) || (state == S_DRAIN);
    assign div_clear  = (state == S_CLEAR);
    assign busy       = (state != S_IDLE);
    assign div_x      = dig_rd ? sel_x : 2'b00;
    assign div_y      = dig_rd ? sel_y : 2'b00;

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state   <= S_IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            dig_cnt <= '0;
            z_out   <= 2'b00;
            z_valid <= 1'b0;
            z_last  <= 1'b0;
            z_id    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt_idx <= rr_pick(req, rr_ptr);
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    dig_cnt <= '0;
                    state   <= S_FEED;
                end
                S_FEED: begin
                    dig_cnt <= dig_cnt + 1'b1;
                    if (dig_cnt == FEED_LAST) begin
                        state <= (ONLINE_DELAY == 0) ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    dig_cnt <= dig_cnt + 1'b1;
                    if (dig_cnt == JOB_LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr <= rr_ptr_nxt;
                    if (|req) begin
                        gnt_idx <= rr_pick(req, rr_ptr_nxt);
                        state   <= S_CLEAR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The first ONLINE_DELAY enabled cycles only fill the divider pipeline.
            if (div_enable && (dig_cnt >= Z_FIRST)) begin
                z_out   <= div_z;
                z_valid <= 1'b1;
                z_id    <= gnt_idx;
                z_last  <= (dig_cnt == JOB_LAST);
            end else begin
                z_valid <= 1'b0;
                z_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_online_div_scheduler.sv
// Bench for online_div_scheduler: per-cycle job-timeline reference model with an echo divider,
// plus scenario tasks for reset, single job, echo, fairness, wrap-around, mid-job drop and reset.
module tb_online_div_scheduler;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int U   = 64;
    localparam int D   = 2;
    localparam int CW  = 11;
    localparam int J   = U + D + 2;

    logic             clk = 1'b0;
    logic             asyn_reset;
    logic [N-1:0]     req;
    logic [2*N-1:0]   x_digit_in;
    logic [2*N-1:0]   y_digit_in;
    logic [N-1:0]     grant;
    logic             dig_rd;
    logic [1:0]       div_x;
    logic [1:0]       div_y;
    logic             div_enable;
    logic             div_clear;
    logic [1:0]       div_z;
    logic [1:0]       z_out;
    logic             z_valid;
    logic             z_last;
    logic [IDW-1:0]   z_id;
    logic             busy;

    always #5 clk = ~clk;

    online_div_scheduler #(
        .NUM_REQ(N), .ID_W(IDW), .UNROLLING(U), .ONLINE_DELAY(D), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .asyn_reset(asyn_reset), .req(req),
        .x_digit_in(x_digit_in), .y_digit_in(y_digit_in),
        .grant(grant), .dig_rd(dig_rd), .div_x(div_x), .div_y(div_y),
        .div_enable(div_enable), .div_clear(div_clear), .div_z(div_z),
        .z_out(z_out), .z_valid(z_valid), .z_last(z_last), .z_id(z_id), .busy(busy)
    );

    // Echo divider: result digit equals the x digit from two enabled cycles earlier.
    logic [1:0] h0, h1;
    always @(posedge clk) begin
        if (asyn_reset) begin
            h0 <= 2'b00;
            h1 <= 2'b00;
        end else if (div_enable) begin
            h0 <= div_x;
            h1 <= h0;
        end
    end
    assign div_z = h1;

    int errors = 0;
    int checks = 0;

    bit         m_busy;
    int         m_id, m_k, m_ptr, m_zid;
    logic [1:0] m_zout;
    bit         m_zvalid, m_zlast;
    logic [1:0] xq[$];

    logic [N-1:0] req_v;
    bit           rst_v;
    int           x_mode;
    int           pat_i;
    logic [1:0]   pat[3];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_id = 0; m_k = 0; m_ptr = 0; m_zid = 0;
        m_zout = 2'b00; m_zvalid = 0; m_zlast = 0;
        xq.delete();
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g == N'(1 << i)) return i;
        return -1;
    endfunction

    // One clock: compare outputs against the model, drive next inputs, advance the model.
    task automatic step();
        logic [1:0]   xs, ys, ex, ey;
        logic [N-1:0] eg;
        bit           feed, en;
        xs   = 2'(x_digit_in >> (2 * m_id));
        ys   = 2'(y_digit_in >> (2 * m_id));
        feed = m_busy && m_k >= 1 && m_k <= U;
        en   = m_busy && m_k >= 1 && m_k <= U + D;
        eg   = (m_busy && m_k <= J - 2) ? N'(1 << m_id) : '0;
        ex   = feed ? xs : 2'b00;
        ey   = feed ? ys : 2'b00;

        checks++; if (grant !== eg) begin errors++; $display("FAIL grant: got %b want %b k=%0d", grant, eg, m_k); end
        checks++; if (div_clear !== (m_busy && m_k == 0)) begin errors++; $display("FAIL div_clear: got %b k=%0d", div_clear, m_k); end
        checks++; if (dig_rd !== feed) begin errors++; $display("FAIL dig_rd: got %b want %b k=%0d", dig_rd, feed, m_k); end
        checks++; if (div_enable !== en) begin errors++; $display("FAIL div_enable: got %b want %b k=%0d", div_enable, en, m_k); end
        checks++; if (busy !== m_busy) begin errors++; $display("FAIL busy: got %b want %b", busy, m_busy); end
        checks++; if (div_x !== ex) begin errors++; $display("FAIL div_x: got %b want %b k=%0d", div_x, ex, m_k); end
        checks++; if (div_y !== ey) begin errors++; $display("FAIL div_y: got %b want %b k=%0d", div_y, ey, m_k); end
        checks++; if (z_valid !== m_zvalid) begin errors++; $display("FAIL z_valid: got %b want %b k=%0d", z_valid, m_zvalid, m_k); end
        checks++; if (z_last !== m_zlast) begin errors++; $display("FAIL z_last: got %b want %b k=%0d", z_last, m_zlast, m_k); end
        checks++; if (z_out !== m_zout) begin errors++; $display("FAIL z_out: got %b want %b k=%0d", z_out, m_zout, m_k); end
        checks++; if (z_id !== IDW'(m_zid)) begin errors++; $display("FAIL z_id: got %0d want %0d", z_id, m_zid); end

        if (x_mode != 0) begin
            for (int i = 0; i < N; i++) x_digit_in[2*i +: 2] = pat[pat_i % 3];
            pat_i++;
        end else begin
            x_digit_in = (2*N)'($urandom);
        end
        y_digit_in = (2*N)'($urandom);
        req        = req_v;
        asyn_reset = rst_v;

        @(posedge clk);
        if (rst_v) begin
            model_reset();
        end else begin
            if (m_busy && m_k >= 1 && m_k <= U) xq.push_back(2'(x_digit_in >> (2 * m_id)));
            if (m_busy && m_k >= D + 1 && m_k <= U + D) begin
                m_zout = xq.pop_front(); m_zvalid = 1; m_zid = m_id; m_zlast = (m_k == U + D);
            end else begin
                m_zvalid = 0; m_zlast = 0;
            end
            if (!m_busy) begin
                if (req_v != 0) begin m_busy = 1; m_id = pick(req_v, m_ptr); m_k = 0; end
            end else if (m_k == J - 1) begin
                m_ptr = (m_id + 1) % N;
                if (req_v != 0) begin m_id = pick(req_v, m_ptr); m_k = 0; end
                else m_busy = 0;
            end else begin
                m_k++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_v = 1; step(); rst_v = 0;
    endtask

    task automatic test_reset();
        req_v = '1;
        rst_v = 1; step(); step(); rst_v = 0; req_v = '0;
        checks++;
        if ({grant, dig_rd, div_enable, div_clear, busy, z_valid, z_last, z_out, z_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b busy=%b z_out=%b z_id=%0d want all zero", grant, busy, z_out, z_id);
        end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_single_job();
        int gc = 0, cc = 0, rc = 0, ec = 0, zc = 0, bc = 0, zl_at = -1, bad_id = 0;
        req_v = 4'b0100; step(); req_v = '0;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
        for (int i = 1; i <= 72; i++) begin
            if (grant == 4'b0100) gc++;
            if (div_clear) cc++;
            if (dig_rd) rc++;
            if (div_enable) ec++;
            if (busy) bc++;
            if (z_valid) begin zc++; if (z_id !== 2'd2) bad_id++; end
            if (z_last) zl_at = i;
            step();
        end
        checks++; if (gc != U + D + 1) begin errors++; $display("FAIL single_grant_len: got %0d want %0d", gc, U + D + 1); end
        checks++; if (cc != 1) begin errors++; $display("FAIL single_clear_len: got %0d want 1", cc); end
        checks++; if (rc != U) begin errors++; $display("FAIL single_rd_len: got %0d want %0d", rc, U); end
        checks++; if (ec != U + D) begin errors++; $display("FAIL single_en_len: got %0d want %0d", ec, U + D); end
        checks++; if (zc != U) begin errors++; $display("FAIL single_zvalid_len: got %0d want %0d", zc, U); end
        checks++; if (bad_id != 0) begin errors++; $display("FAIL single_zid: got %0d wrong ids want 0", bad_id); end
        checks++; if (zl_at != J) begin errors++; $display("FAIL single_zlast_at: got t+%0d want t+%0d", zl_at, J); end
        checks++; if (bc != J) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", bc, J); end
    endtask

    task automatic test_echo();
        logic [1:0] z[$];
        int last_pos = -1, bad = 0;
        x_mode = 1;
        req_v = 4'b0001; step(); req_v = '0;
        for (int i = 0; i < 75; i++) begin
            if (z_valid) begin z.push_back(z_out); if (z_last) last_pos = z.size(); end
            step();
        end
        x_mode = 0;
        checks++; if (z.size() != U) begin errors++; $display("FAIL echo_count: got %0d want %0d", z.size(), U); end
        for (int i = 0; i + 1 < z.size(); i++) begin
            if (z[i] == 2'b01 && z[i+1] != 2'b11) bad++;
            else if (z[i] == 2'b11 && z[i+1] != 2'b00) bad++;
            else if (z[i] == 2'b00 && z[i+1] != 2'b01) bad++;
            else if (z[i] == 2'b10) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL echo_sequence: got %0d breaks want 0", bad); end
        checks++; if (last_pos != U) begin errors++; $display("FAIL echo_zlast_pos: got %0d want %0d", last_pos, U); end
    endtask

    task automatic test_fairness();
        int order[$];
        int stamp[$];
        bit idle_seen = 0;
        do_reset();
        req_v = 4'b1111;
        for (int t = 0; t < 400 && order.size() < 5; t++) begin
            if (div_clear) begin order.push_back(onehot_idx(grant)); stamp.push_back(t); end
            if (order.size() > 0 && !busy) idle_seen = 1;
            step();
        end
        req_v = '0;
        checks++;
        if (order.size() != 5) begin
            errors++; $display("FAIL fairness_timeout: got %0d grants want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (order[i] != i % N) begin errors++; $display("FAIL fairness_order[%0d]: got %0d want %0d", i, order[i], i % N); end
            end
            for (int i = 1; i < 5; i++) begin
                checks++; if (stamp[i] - stamp[i-1] != J) begin errors++; $display("FAIL fairness_period: got %0d want %0d", stamp[i] - stamp[i-1], J); end
            end
        end
        checks++; if (idle_seen) begin errors++; $display("FAIL fairness_idle: got idle between jobs want none"); end
        for (int t = 0; t < 100 && busy; t++) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fairness_return_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_wrap();
        int order[$];
        do_reset();
        req_v = 4'b0010; step(); req_v = '0;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_first: got %b want 0010", grant); end
        repeat (10) step();
        req_v = 4'b1001;
        for (int t = 0; t < 300 && order.size() < 2; t++) begin
            if (div_clear) order.push_back(onehot_idx(grant));
            step();
        end
        req_v = '0;
        checks++;
        if (order.size() != 2) begin
            errors++; $display("FAIL wrap_timeout: got %0d grants want 2", order.size());
        end else begin
            checks++; if (order[0] != 3) begin errors++; $display("FAIL wrap_order0: got %0d want 3", order[0]); end
            checks++; if (order[1] != 0) begin errors++; $display("FAIL wrap_order1: got %0d want 0", order[1]); end
        end
        for (int t = 0; t < 100 && busy; t++) step();
    endtask

    task automatic test_drop();
        int zc = 0;
        req_v = 4'b0001; step();
        for (int i = 0; i < 21; i++) begin if (z_valid) zc++; step(); end
        req_v = '0;
        for (int i = 0; i < 60; i++) begin if (z_valid) zc++; step(); end
        checks++; if (zc != U) begin errors++; $display("FAIL drop_zvalid_count: got %0d want %0d", zc, U); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int zc = 0;
        req_v = 4'b0001; step(); req_v = '0;
        repeat (11) step();
        checks++; if (dig_rd !== 1'b1) begin errors++; $display("FAIL midreset_pre_feed: dig_rd=%b want 1", dig_rd); end
        do_reset();
        checks++;
        if ({busy, grant, div_enable} !== '0) begin
            errors++; $display("FAIL midreset_outputs: busy=%b grant=%b en=%b want 0", busy, grant, div_enable);
        end
        for (int i = 0; i < 80; i++) begin if (z_valid || z_last) zc++; step(); end
        checks++; if (zc != 0) begin errors++; $display("FAIL midreset_zvalid: got %0d cycles want 0", zc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            req_v = ($urandom_range(0, 9) < 3) ? '0 : N'($urandom);
            rst_v = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_v = 0; req_v = '0;
    endtask

    initial begin
        pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b00;
        x_mode = 0; pat_i = 0;
        asyn_reset = 1'b1; req = '0; x_digit_in = '0; y_digit_in = '0;
        req_v = '0; rst_v = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_single_job();
        test_echo();
        test_fairness();
        test_wrap();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
